pid_gain_regs: RTL and testbench

Gain register bank directly downstream of the I2C slave. It watches the slave's state, register address and assembled data, and commits each acknowledged write into a shadow copy of Kp, Ki or Kd. Shadow gains move to the active gains that drive the PID datapath only on the controller's `apply` strobe, so a gain never changes mid-computation. It also serialises the active gain back onto the read-data line during I2C READ frames.

---
 rtl/pid_gain_regs_if.sv | 27 ++
 rtl/pid_gain_regs.sv | 91 +++++++++
 tb/tb_pid_gain_regs.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pid_gain_regs_if.sv
// I2C slave to gain-register-bank link: slave state, address, write data and bit
// index flow towards the bank, and serial read-back data flows back to the slave.
interface pid_gain_regs_if #(
  parameter int GAIN_W = 6
);
  logic [4:0]        i2c_state;
  logic [7:0]        i2c_reg_addr;
  logic [GAIN_W-1:0] i2c_update_value;
  logic [2:0]        i2c_data_index;
  logic              read_bit;

  modport master (
    output i2c_state,
    output i2c_reg_addr,
    output i2c_update_value,
    output i2c_data_index,
    input  read_bit
  );

  modport slave (
    input  i2c_state,
    input  i2c_reg_addr,
    input  i2c_update_value,
    input  i2c_data_index,
    output read_bit
  );
endinterface

// File: rtl/pid_gain_regs.sv
// Kp/Ki/Kd gain bank: acknowledged I2C writes land in shadow registers, and the
// PID loop's apply strobe moves them to the active gains; active gains are read back serially.
module pid_gain_regs #(
  parameter int                GAIN_W  = 6,
  parameter logic [7:0]        ADDR_KP = 8'h00,
  parameter logic [7:0]        ADDR_KI = 8'h01,
  parameter logic [7:0]        ADDR_KD = 8'h02,
  parameter logic [GAIN_W-1:0] KP_RST  = '0,
  parameter logic [GAIN_W-1:0] KI_RST  = '0,
  parameter logic [GAIN_W-1:0] KD_RST  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              apply,
  pid_gain_regs_if.slave    bus,
  output logic [GAIN_W-1:0] kp,
  output logic [GAIN_W-1:0] ki,
  output logic [GAIN_W-1:0] kd,
  output logic [2:0]        pending,
  output logic              commit,
  output logic [1:0]        commit_sel
);

  localparam logic [4:0] ST_WRITE_ACK = 5'd8;
  localparam logic [4:0] ST_READ      = 5'd9;
  localparam logic [4:0] ST_STOP      = 5'd11;

  logic [4:0]        prev_state;
  logic [GAIN_W-1:0] kp_sh, ki_sh, kd_sh;
  logic [2:0]        hit;
  logic              acked;
  logic [2:0]        commit_mask;
  logic [1:0]        sel_next;
  logic [7:0]        rd_byte;

  // An ACKed write is the WRITE_ACK -> STOP transition; a NACK goes to IDLE instead.
  always_comb begin
    hit         = {bus.i2c_reg_addr == ADDR_KD,
                   bus.i2c_reg_addr == ADDR_KI,
                   bus.i2c_reg_addr == ADDR_KP};
    acked       = ena && (prev_state == ST_WRITE_ACK) && (bus.i2c_state == ST_STOP);
    commit_mask = acked ? hit : 3'b000;
    sel_next    = commit_mask[0] ? 2'd0 : (commit_mask[1] ? 2'd1 : 2'd2);
    rd_byte     = '0;
    if (hit[0])
      rd_byte[GAIN_W-1:0] = kp;
    else if (hit[1])
      rd_byte[GAIN_W-1:0] = ki;
    else if (hit[2])
      rd_byte[GAIN_W-1:0] = kd;
  end

  // Apply copies the pre-commit shadows, so a same-cycle write stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_state   <= '0;
      kp_sh        <= KP_RST;
      ki_sh        <= KI_RST;
      kd_sh        <= KD_RST;
      kp           <= KP_RST;
      ki           <= KI_RST;
      kd           <= KD_RST;
      pending      <= '0;
      commit       <= 1'b0;
      commit_sel   <= '0;
      bus.read_bit <= 1'b1;
    end else begin
      prev_state <= bus.i2c_state;
      if (apply) begin
        kp      <= kp_sh;
        ki      <= ki_sh;
        kd      <= kd_sh;
        pending <= commit_mask;
      end else begin
        pending <= pending | commit_mask;
      end
      if (commit_mask[0])
        kp_sh <= bus.i2c_update_value;
      if (commit_mask[1])
        ki_sh <= bus.i2c_update_value;
      if (commit_mask[2])
        kd_sh <= bus.i2c_update_value;
      commit <= |commit_mask;
      if (|commit_mask)
        commit_sel <= sel_next;
      bus.read_bit <= (bus.i2c_state == ST_READ) ? rd_byte[bus.i2c_data_index] : 1'b1;
    end
  end

endmodule

// File: tb/tb_pid_gain_regs.sv
// Self-checking bench for pid_gain_regs: directed scenarios followed by random I2C
// traffic, every cycle compared against a transaction-level model of the gain bank.
module tb_pid_gain_regs;

  logic       clk = 1'b0;
  logic       rst, ena, apply;
  logic [5:0] kp, ki, kd;
  logic [2:0] pending;
  logic       commit;
  logic [1:0] commit_sel;

  int errors = 0;
  int checks = 0;

  // Model: gain registers indexed 0=Kp, 1=Ki, 2=Kd.
  int m_shadow[3];
  int m_active[3];
  bit m_pend[3];
  int m_commit, m_sel, m_read, m_prev;

  pid_gain_regs_if #(.GAIN_W(6)) bus ();

  pid_gain_regs #(.GAIN_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .apply      (apply),
    .bus        (bus),
    .kp         (kp),
    .ki         (ki),
    .kd         (kd),
    .pending    (pending),
    .commit     (commit),
    .commit_sel (commit_sel)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep();
    int idx;
    int byte_val;
    bit acked;
    if (rst) begin
      for (int g = 0; g < 3; g++) begin
        m_shadow[g] = 0;
        m_active[g] = 0;
        m_pend[g]   = 0;
      end
      m_commit = 0;
      m_sel    = 0;
      m_read   = 1;
      m_prev   = 0;
    end else begin
      idx = (bus.i2c_reg_addr < 3) ? int'(bus.i2c_reg_addr) : -1;
      acked = ena && (m_prev == 8) && (int'(bus.i2c_state) == 11);
      if (int'(bus.i2c_state) == 9) begin
        byte_val = (idx >= 0) ? m_active[idx] : 0;
        m_read = (byte_val >> bus.i2c_data_index) & 1;
      end else begin
        m_read = 1;
      end
      if (apply) begin
        for (int g = 0; g < 3; g++) begin
          m_active[g] = m_shadow[g];
          m_pend[g]   = 0;
        end
      end
      m_commit = 0;
      if (acked && idx >= 0) begin
        m_shadow[idx] = int'(bus.i2c_update_value);
        m_pend[idx]   = 1;
        m_commit      = 1;
        m_sel         = idx;
      end
      m_prev = int'(bus.i2c_state);
    end
  endtask

  task automatic checkOutput();
    checkVal("kp", {26'b0, kp}, m_active[0]);
    checkVal("ki", {26'b0, ki}, m_active[1]);
    checkVal("kd", {26'b0, kd}, m_active[2]);
    checkVal("pending", {29'b0, pending}, {29'b0, m_pend[2], m_pend[1], m_pend[0]});
    checkVal("commit", {31'b0, commit}, m_commit);
    checkVal("commit_sel", {30'b0, commit_sel}, m_sel);
    checkVal("read_bit", {31'b0, bus.read_bit}, m_read);
  endtask

  // One clock cycle: drive inputs, advance the model, sample just after the edge.
  task automatic applyStimulus(input logic r, input logic en, input logic [4:0] st,
                               input logic [7:0] addr, input logic [5:0] data,
                               input logic [2:0] index, input logic ap);
    rst                  = r;
    ena                  = en;
    bus.i2c_state        = st;
    bus.i2c_reg_addr     = addr;
    bus.i2c_update_value = data;
    bus.i2c_data_index   = index;
    apply                = ap;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic writeFrame(input logic en, input logic [7:0] addr, input logic [5:0] data,
                            input logic ap_on_stop);
    applyStimulus(0, en, 5'd8, addr, data, 3'd0, 0);
    applyStimulus(0, en, 5'd11, addr, data, 3'd0, ap_on_stop);
  endtask

  initial begin
    logic [7:0] rb_exp;
    logic [4:0] st_opts[5];
    st_opts = '{5'd0, 5'd7, 5'd8, 5'd9, 5'd11};
    rb_exp  = 8'b0010_0101;
    rst = 1'b1; ena = 1'b1; apply = 1'b0;
    bus.i2c_state = '0; bus.i2c_reg_addr = '0;
    bus.i2c_update_value = '0; bus.i2c_data_index = '0;

    $display("[TB] reset");
    applyStimulus(1, 1, 5'd0, 8'h00, 6'h00, 3'd0, 0);
    checkVal("rst_read_bit", {31'b0, bus.read_bit}, 1);
    checkVal("rst_pending", {29'b0, pending}, 0);

    $display("[TB] ACKed write to Kd");
    applyStimulus(0, 1, 5'd7, 8'h02, 6'h2A, 3'd0, 0);
    writeFrame(1, 8'h02, 6'h2A, 0);
    checkVal("kd_commit", {31'b0, commit}, 1);
    checkVal("kd_sel", {30'b0, commit_sel}, 2);
    checkVal("kd_pending", {29'b0, pending}, 3'b100);
    checkVal("kd_not_active", {26'b0, kd}, 0);
    applyStimulus(0, 1, 5'd0, 8'h02, 6'h00, 3'd0, 0);
    checkVal("kd_commit_one_cycle", {31'b0, commit}, 0);
    applyStimulus(0, 1, 5'd0, 8'h02, 6'h00, 3'd0, 1);
    checkVal("kd_applied", {26'b0, kd}, 6'h2A);
    checkVal("kd_pending_clr", {29'b0, pending}, 0);

    $display("[TB] NACK and bad address");
    applyStimulus(0, 1, 5'd8, 8'h01, 6'h15, 3'd0, 0);
    applyStimulus(0, 1, 5'd0, 8'h01, 6'h15, 3'd0, 0);
    checkVal("nack_commit", {31'b0, commit}, 0);
    checkVal("nack_pending", {29'b0, pending}, 0);
    writeFrame(1, 8'h05, 6'h15, 0);
    checkVal("badaddr_commit", {31'b0, commit}, 0);
    checkVal("badaddr_sel", {30'b0, commit_sel}, 2);

    $display("[TB] simultaneous commit and apply");
    writeFrame(1, 8'h00, 6'h03, 0);
    applyStimulus(0, 1, 5'd0, 8'h00, 6'h00, 3'd0, 0);
    writeFrame(1, 8'h00, 6'h3F, 1);
    checkVal("sim_kp", {26'b0, kp}, 6'h03);
    checkVal("sim_pending", {29'b0, pending}, 3'b001);
    applyStimulus(0, 1, 5'd0, 8'h00, 6'h00, 3'd0, 1);
    checkVal("sim_kp_second", {26'b0, kp}, 6'h3F);

    $display("[TB] read-back");
    writeFrame(1, 8'h01, 6'h25, 0);
    applyStimulus(0, 1, 5'd0, 8'h01, 6'h00, 3'd0, 1);
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(0, 1, 5'd9, 8'h01, 6'h00, 3'(i), 0);
      checkVal($sformatf("readback_bit%0d", i), {31'b0, bus.read_bit}, {31'b0, rb_exp[i]});
    end
    applyStimulus(0, 1, 5'd0, 8'h01, 6'h00, 3'd0, 0);
    checkVal("readback_release", {31'b0, bus.read_bit}, 1);
    applyStimulus(0, 1, 5'd9, 8'h07, 6'h00, 3'd0, 0);
    checkVal("readback_unknown", {31'b0, bus.read_bit}, 0);

    $display("[TB] disable");
    writeFrame(1, 8'h02, 6'h07, 0);
    writeFrame(0, 8'h00, 6'h11, 0);
    checkVal("dis_commit", {31'b0, commit}, 0);
    applyStimulus(0, 0, 5'd0, 8'h00, 6'h00, 3'd0, 1);
    checkVal("dis_apply_kd", {26'b0, kd}, 6'h07);
    checkVal("dis_apply_kp", {26'b0, kp}, 6'h3F);

    $display("[TB] reset mid-operation");
    writeFrame(1, 8'h00, 6'h01, 0);
    writeFrame(1, 8'h01, 6'h02, 0);
    writeFrame(1, 8'h02, 6'h03, 0);
    checkVal("pre_rst_pending", {29'b0, pending}, 3'b111);
    applyStimulus(1, 1, 5'd9, 8'h00, 6'h00, 3'd0, 1);
    checkVal("rst_kp", {26'b0, kp}, 0);
    checkVal("rst_kd", {26'b0, kd}, 0);
    checkVal("rst_pending_mid", {29'b0, pending}, 0);
    checkVal("rst_read_mid", {31'b0, bus.read_bit}, 1);

    $display("[TB] random traffic");
    for (int n = 0; n < 2000; n++) begin
      logic [7:0] addr;
      addr = ($urandom_range(0, 3) == 3) ? 8'($urandom) : 8'($urandom_range(0, 2));
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 7) != 0),
                    st_opts[$urandom_range(0, 4)],
                    addr,
                    6'($urandom),
                    3'($urandom),
                    ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
